// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and parallel byte outputs of the UART receiver
interface uart_rx_if;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    modport slave (
        input  serial_in,
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );

    modport master (
        output serial_in,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, one-cycle valid/framing-error strobes
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rx_q, rx_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          framing_error_q, framing_error_d;

    logic fall_edge;
    logic at_half;
    logic at_end;

    assign fall_edge = !rx_q && prev_q;
    assign at_half   = (cnt_q == HALF_M1);
    assign at_end    = (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            sync1_q         <= 1'b1;
            rx_q            <= 1'b1;
            prev_q          <= 1'b1;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shreg_q         <= '0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync1_q         <= sync1_d;
            rx_q            <= rx_d;
            prev_q          <= prev_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shreg_q         <= shreg_d;
            data_out_q      <= data_out_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (fall_edge) state_d = START;
            START: if (at_half) state_d = rx_q ? IDLE : DATA;
            DATA:  if (at_end && bit_idx_q == 3'd7) state_d = STOP;
            STOP:  if (at_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and strobes; strobes default low so each lasts exactly one cycle.
    always_comb begin
        sync1_d         = bus.serial_in;
        rx_d            = sync1_q;
        prev_d          = rx_q;
        cnt_d           = cnt_q;
        bit_idx_d       = bit_idx_q;
        shreg_d         = shreg_q;
        data_out_d      = data_out_q;
        data_valid_d    = 1'b0;
        framing_error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            START: begin
                if (at_half) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (at_end) begin
                    cnt_d              = '0;
                    shreg_d[bit_idx_q] = rx_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (at_end) begin
                    cnt_d = '0;
                    if (rx_q) begin
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                    end else begin
                        framing_error_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign bus.data_out      = data_out_q;
    assign bus.data_valid    = data_valid_q;
    assign bus.framing_error = framing_error_q;
    assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed 8N1 frames
module tb_uart_rx;
    localparam int CPB = 16;

    logic clk;
    logic reset;
    uart_rx_if u_if();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   busy_runs[$];
    int   valid_times[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_run = 0;
    logic [7:0] model_last = 8'h00;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe cycle pops one expected event.
    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
        end else begin
            if (u_if.busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                busy_runs.push_back(busy_run);
                busy_run = 0;
            end
            if (u_if.data_valid && u_if.framing_error)
                chk("both_strobes", 32'd1, 32'd0);
            if (u_if.data_valid || u_if.framing_error) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {31'd0, u_if.framing_error}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("event_kind_is_err", {31'd0, u_if.framing_error}, {31'd0, e.is_err});
                    chk("event_data_out", {24'd0, u_if.data_out}, {24'd0, e.data});
                    if (u_if.data_valid) valid_times.push_back(cyc);
                end
            end
        end
    end

    task automatic hold(input logic lvl, input int cycles);
        u_if.serial_in = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
    endtask

    task automatic expect_good(input logic [7:0] b);
        exp_q.push_back('{1'b0, b});
        model_last = b;
    endtask

    task automatic expect_err();
        exp_q.push_back('{1'b1, model_last});
    endtask

    initial begin
        logic [7:0] c3;
        reset = 1'b1;
        u_if.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data_out", {24'd0, u_if.data_out}, 32'h00);
        chk("reset_data_valid", {31'd0, u_if.data_valid}, 32'd0);
        chk("reset_framing_error", {31'd0, u_if.framing_error}, 32'd0);
        chk("reset_busy", {31'd0, u_if.busy}, 32'd0);
        reset = 1'b0;
        hold(1'b1, 2 * CPB);

        // Single frame 0xA5
        busy_runs.delete();
        expect_good(8'hA5);
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 3 * CPB);
        chk("a5_busy_runs", busy_runs.size(), 32'd1);
        if (busy_runs.size() > 0)
            chk("a5_busy_len_150_156", {31'd0, (busy_runs[0] >= 150 && busy_runs[0] <= 156)}, 32'd1);

        // Back-to-back 0x00 then 0xFF
        valid_times.delete();
        expect_good(8'h00);
        expect_good(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 3 * CPB);
        chk("b2b_valid_count", valid_times.size(), 32'd2);
        if (valid_times.size() == 2)
            chk("b2b_spacing", valid_times[1] - valid_times[0], 32'd160);

        // Good 0x11 then 0x3C with bad stop bit
        expect_good(8'h11);
        send_frame(8'h11, 1'b1);
        hold(1'b1, 2 * CPB);
        expect_err();
        send_frame(8'h3C, 1'b0);
        hold(1'b1, 3 * CPB);
        chk("ferr_drained", exp_q.size(), 32'd0);

        // Glitch: 4 low cycles
        busy_runs.delete();
        hold(1'b0, 4);
        hold(1'b1, 3 * CPB);
        chk("glitch_busy_runs", busy_runs.size(), 32'd1);
        if (busy_runs.size() > 0)
            chk("glitch_busy_short", {31'd0, (busy_runs[0] >= 1 && busy_runs[0] <= 12)}, 32'd1);
        chk("glitch_data_out", {24'd0, u_if.data_out}, 32'h11);

        // Break of 40 bit times, then 0x5A
        expect_err();
        hold(1'b0, 40 * CPB);
        hold(1'b1, 2 * CPB);
        chk("break_drained", exp_q.size(), 32'd0);
        expect_good(8'h5A);
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 3 * CPB);

        // Reset during data bit 4, then 0xC3
        c3 = 8'hC3;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(c3[i], CPB);
        hold(c3[4], CPB / 2);
        chk("pre_reset_busy", {31'd0, u_if.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, u_if.busy}, 32'd0);
        chk("rst_mid_data_out", {24'd0, u_if.data_out}, 32'h00);
        chk("rst_mid_data_valid", {31'd0, u_if.data_valid}, 32'd0);
        chk("rst_mid_framing_error", {31'd0, u_if.framing_error}, 32'd0);
        u_if.serial_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_last = 8'h00;
        hold(1'b1, 2 * CPB);
        valid_times.delete();
        expect_good(8'hC3);
        send_frame(8'hC3, 1'b1);
        hold(1'b1, 3 * CPB);
        chk("c3_valid_count", valid_times.size(), 32'd1);

        for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(negedge clk);
        chk("final_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the receive-side counterpart of the team's UART transmitter datapath. It samples an asynchronous 8N1 serial line (idle high, one start bit, 8 data bits LSB first, one stop bit) at mid-bit using a per-bit clock counter. It presents each received byte on a parallel bus with a one-cycle valid strobe, and flags frames whose stop bit is low.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 4..65535.
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- serial_in  input  1  asynchronous serial line; idle level 1.
- data_out  output  8  last correctly framed byte; bit 0 is the first data bit received.
- data_valid  output  1  one-cycle pulse when data_out is updated with a good frame.
- framing_error  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high while a frame is being received (any state other than IDLE).

## Operation
- Input path: serial_in passes through a 2-flop synchronizer, then a third flop (prev). Reset value of all three flops is 1. All decisions use the synchronized value rx.
- Counters: cnt is wide enough for CLKS_PER_BIT-1. bit_idx is 3 bits. shreg is 8 bits.
- FSM states are IDLE, START, DATA, STOP.
- IDLE
  - A falling edge (rx==0 and prev==1) moves the FSM to START with cnt=0.
  - A line held low does not retrigger; a new frame requires a 1 to 0 transition.
- START
  - cnt increments each cycle.
  - When cnt == CLKS_PER_BIT/2 - 1 (integer division), rx is sampled.
    - rx==0: go to DATA with cnt=0 and bit_idx=0.
    - rx==1: false start (glitch); return to IDLE with no output pulse.
- DATA
  - When cnt == CLKS_PER_BIT-1, rx is written into shreg[bit_idx] and cnt resets to 0.
  - After bit_idx==7 is sampled, go to STOP; otherwise bit_idx increments.
- STOP
  - When cnt == CLKS_PER_BIT-1, rx is sampled and the FSM returns to IDLE.
    - rx==1: data_out <= shreg and data_valid pulses.
    - rx==0: framing_error pulses and data_out keeps its previous value.
- data_valid and framing_error are never high in the same cycle.
- Each of data_valid and framing_error is high for exactly one cycle per frame.
- No flow control exists. A downstream consumer must capture data_out when data_valid is high; data_out is stable until the next good frame.
- Reset mid-frame: the FSM returns to IDLE and busy, data_valid and framing_error go low asynchronously. data_out resets to 0x00 and no partial byte is ever emitted.
- Reset values: data_out=0x00, data_valid=0, framing_error=0, busy=0, state=IDLE, cnt=0, bit_idx=0, shreg=0x00.

## Timing
- Synchronizer latency: a serial_in edge is visible on rx 2 cycles later. The falling edge is detected in the cycle rx first reads 0.
- busy rises in the cycle after detection and stays high until the cycle after the STOP sample.
- Sample points, relative to the detection edge (E) at which START is entered:
  - start bit at E + CLKS_PER_BIT/2;
  - data bit k (k = 0..7) at E + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop bit at E + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- data_valid or framing_error is registered high in the cycle immediately after the stop-bit sample edge, in the same cycle busy falls.
- Back-to-back frames: the FSM is in IDLE half a bit before the nominal stop end, so a start bit immediately following a stop bit is detected normally.
- Tolerates a baud mismatch of about ±4% at CLKS_PER_BIT=16 (samples stay inside the bit cell).

## Test plan
All scenarios use CLKS_PER_BIT=16 with serial_in driven at exactly 16 clk per bit.
- Single frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) -> exactly one data_valid pulse, data_out=0xA5, framing_error stays 0. busy high for about 154 cycles.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses 160 cycles apart, data_out=0x00 then 0xFF.
- Frame 0x3C with stop bit 0 after an earlier good 0x11 -> framing_error pulses once, data_valid stays 0, data_out remains 0x11.
- Glitch: serial_in low for 4 cycles, then high -> busy pulses briefly, then returns to IDLE. No data_valid or framing_error; data_out unchanged.
- Break: serial_in held low for 40 bit times, then high, then a valid frame 0x5A -> the break produces exactly one framing_error. The following 0x5A produces data_valid with data_out=0x5A, with no extra frames in between.
- Reset asserted during data bit 4 of a frame, released, then a valid frame 0xC3 -> all outputs 0 immediately on reset assertion. Exactly one data_valid follows, with data_out=0xC3.
